// File: rtl/mem_copier.sv
// mem_copier: bus-initiator DMA engine copying a block of words via one read then one write per word
module mem_copier #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  req,
  input  logic                  gnt,
  output tri   [ADDR_WIDTH-1:0] mem_addr,
  output tri   [WORD_SIZE-1:0]  mem_data,
  input  logic [WORD_SIZE-1:0]  mem_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  mem_en
);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t state, state_nx;
  logic own;
  logic [ADDR_WIDTH-1:0] src_cur, dst_cur;
  logic [ADDR_WIDTH:0] count;
  logic [WORD_SIZE-1:0] data_buf;
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // next state: an ungranted cycle simply holds the current state
  always_comb begin
    state_nx = state == IDLE ? ((start && len != 0) ? RD : IDLE)
             : !gnt ? state
             : state == RD ? WR
             : count == 1 ? IDLE : RD;
  end
  // bus strobes decoded from state and grant, so the bus drops in the same cycle gnt falls
  always_comb begin
    busy   = state != IDLE;
    req    = busy;
    own    = busy && gnt;
    mem_en = own;
    mem_rd = own && state == RD;
    mem_wr = own && state == WR;
  end
  assign mem_addr = own ? (state == RD ? src_cur : dst_cur) : 'z;
  assign mem_data = mem_wr ? data_buf : 'z;
  // datapath: latch the job, capture read data, advance pointers after each granted write
  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      count    <= '0;
      src_cur  <= '0;
      dst_cur  <= '0;
      data_buf <= '0;
    end else begin
      done <= (state == IDLE && start && len == 0) || (mem_wr && count == 1);
      if (state == IDLE && start) begin
        src_cur <= src_addr;
        dst_cur <= dst_addr;
        count   <= len;
      end
      if (mem_rd) data_buf <= mem_rdata;
      if (mem_wr) begin
        src_cur <= src_cur + 1'b1;
        dst_cur <= dst_cur + 1'b1;
        count   <= count - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_copier.sv
// tb_mem_copier: directed checks of mem_copier against a behavioural bus memory
module tb_mem_copier;
  logic clk = 0, rst = 1, start = 0, gnt = 1;
  logic [15:0] src_addr = 0, dst_addr = 0;
  logic [16:0] len = 0;
  logic busy, done, req, mem_rd, mem_wr, mem_en;
  wire [15:0] mem_addr;
  wire [31:0] mem_data;
  logic [31:0] mem_rdata;
  logic [31:0] mem [0:65535];
  logic tb_we = 0;
  logic [15:0] tb_wa = 0;
  logic [31:0] tb_wd = 0;
  int total = 0, bad = 0, cyc = 0, s_cyc = 0, base = 0;
  int done_cnt = 0, done_cyc = 0, done_busy = 0, rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  int ung_bad = 0, stall_cnt = 0, req_bad = 0, busy_cnt = 0;
  logic [15:0] rd_q[$];

  mem_copier dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .req(req), .gnt(gnt), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_rdata(mem_rdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_en(mem_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_rdata = (mem_en && mem_rd) ? mem[mem_addr] : '0;
  always @(posedge clk)
    if (mem_en && mem_wr) mem[mem_addr] <= mem_data;
    else if (tb_we) mem[tb_wa] <= tb_wd;

  always @(negedge clk) begin
    if (done) begin done_cnt++; done_cyc = cyc; done_busy = busy; end
    if (mem_rd) begin rd_cnt++; rd_q.push_back(mem_addr); end
    if (mem_wr) wr_cnt++;
    if (mem_rd && mem_wr) both_cnt++;
    if (!gnt && (mem_en || mem_rd || mem_wr)) ung_bad++;
    if (busy && !gnt) stall_cnt++;
    if (req != busy) req_bad++;
    if (busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ld(input logic [15:0] a, input logic [31:0] d);
    tb_we = 1; tb_wa = a; tb_wd = d;
    @(posedge clk); #1 tb_we = 0;
  endtask

  task automatic go(input logic [15:0] s, input logic [15:0] d, input logic [16:0] n);
    base = done_cnt;
    src_addr = s; dst_addr = d; len = n; start = 1;
    @(posedge clk); #1 start = 0;
    s_cyc = cyc;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && done_cnt == base; i++) @(negedge clk);
    chk("done_seen", 64'(done_cnt != base), 1);
  endtask

  initial begin
    int r0, w0, b0, q0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", req, 0);
    chk("rst_strobes", {mem_en, mem_rd, mem_wr}, 0);
    rst = 0;
    // basic copy
    for (int i = 0; i < 4; i++) ld(16'h10 + 16'(i), 32'hA000_0000 + i);
    r0 = rd_cnt; w0 = wr_cnt;
    go(16'h10, 16'h80, 4);
    wait_done();
    chk("basic_lat", done_cyc - s_cyc, 8);
    chk("basic_busy_at_done", done_busy, 0);
    for (int i = 0; i < 4; i++) chk("basic_data", mem[16'h80 + 16'(i)], 32'hA000_0000 + i);
    chk("basic_rd", rd_cnt - r0, 4);
    chk("basic_wr", wr_cnt - w0, 4);
    chk("basic_overlap", both_cnt, 0);
    @(negedge clk);
    chk("basic_pulse", done, 0);
    chk("basic_done_cnt", done_cnt - base, 1);
    // zero length
    ld(16'h90, 32'h5555_AAAA);
    r0 = rd_cnt; w0 = wr_cnt; b0 = busy_cnt;
    go(16'h10, 16'h90, 0);
    wait_done();
    chk("zero_lat", done_cyc - s_cyc, 0);
    repeat (3) @(negedge clk);
    chk("zero_busy", busy_cnt - b0, 0);
    chk("zero_strobes", (rd_cnt - r0) + (wr_cnt - w0), 0);
    chk("zero_mem", mem[16'h90], 32'h5555_AAAA);
    chk("zero_done_cnt", done_cnt - base, 1);
    // grant stall
    ld(16'h20, 32'hC0C0_0000); ld(16'h21, 32'hC1C1_0001);
    b0 = stall_cnt;
    gnt = 0;
    go(16'h20, 16'h500, 2);
    repeat (3) @(posedge clk);
    #1 gnt = 1;
    repeat (3) @(posedge clk);
    #1 gnt = 0;
    repeat (2) @(posedge clk);
    #1 gnt = 1;
    wait_done();
    chk("stall_lat", done_cyc - s_cyc, 9);
    chk("stall_cycles", stall_cnt - b0, 5);
    chk("stall_ungranted_bus", ung_bad, 0);
    chk("stall_d0", mem[16'h500], 32'hC0C0_0000);
    chk("stall_d1", mem[16'h501], 32'hC1C1_0001);
    // wrap
    ld(16'hFFFE, 32'h1111_0000); ld(16'hFFFF, 32'h1111_0001);
    ld(16'h0000, 32'h1111_0002); ld(16'h0001, 32'h1111_0003);
    q0 = rd_q.size();
    go(16'hFFFE, 16'h0100, 4);
    wait_done();
    chk("wrap_rd_n", rd_q.size() - q0, 4);
    chk("wrap_ra0", rd_q[q0], 16'hFFFE);
    chk("wrap_ra1", rd_q[q0 + 1], 16'hFFFF);
    chk("wrap_ra2", rd_q[q0 + 2], 16'h0000);
    chk("wrap_ra3", rd_q[q0 + 3], 16'h0001);
    for (int i = 0; i < 4; i++) chk("wrap_data", mem[16'h100 + 16'(i)], 32'h1111_0000 + i);
    // overlap with an ignored second start
    for (int i = 0; i < 4; i++) ld(16'(i), 32'(i + 1));
    ld(16'h200, 32'hDEAD_BEEF);
    go(16'h0, 16'h1, 3);
    @(posedge clk); #1;
    src_addr = 16'h10; dst_addr = 16'h200; len = 1; start = 1;
    @(posedge clk); #1 start = 0;
    wait_done();
    chk("ovl_lat", done_cyc - s_cyc, 6);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) chk("ovl_data", mem[16'(i)], 1);
    chk("ovl_ignored_mem", mem[16'h200], 32'hDEAD_BEEF);
    chk("ovl_ignored_busy", busy, 0);
    chk("ovl_done_cnt", done_cnt - base, 1);
    // reset after the second write
    for (int i = 0; i < 4; i++) begin ld(16'h40 + 16'(i), 32'hB000_0000 + i); ld(16'h300 + 16'(i), 0); end
    go(16'h40, 16'h300, 4);
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("rmid_busy", busy, 0);
    chk("rmid_req", req, 0);
    chk("rmid_strobes", {mem_en, mem_rd, mem_wr}, 0);
    repeat (10) @(negedge clk);
    chk("rmid_no_done", done_cnt - base, 0);
    chk("rmid_d0", mem[16'h300], 32'hB000_0000);
    chk("rmid_d1", mem[16'h301], 32'hB000_0001);
    chk("rmid_d2", mem[16'h302], 0);
    chk("rmid_d3", mem[16'h303], 0);
    chk("req_tracks_busy", req_bad, 0);
    chk("never_rd_and_wr", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
